// File: rtl/calc_pkg.sv
// calc_pkg: shared states, op bit positions, saturation limits and LED codes for calc_sequencer
package calc_pkg;
  typedef enum logic [2:0] {WAIT_A, ARM_A, WAIT_B, ARM_B, COMPUTE, DONE} state_e;
  localparam int OP_SUB = 0;
  localparam int OP_CHAIN = 1;
  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;
  localparam logic [1:0] LED_A = 2'b01;
  localparam logic [1:0] LED_B = 2'b10;
  localparam logic [1:0] LED_DONE = 2'b11;
  function automatic logic [15:0] saturate(input logic [16:0] r, input logic ovf);
    return ovf ? (r[16] ? SAT_NEG : SAT_POS) : r[15:0];
  endfunction
endpackage

// File: rtl/edge_detect_rst.sv
// edge_detect_rst: one-bit rising-edge detector whose history register resets to RST_VAL
module edge_detect_rst #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);
  logic prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= RST_VAL;
    else prev_q <= d_i;
  assign rise_o = d_i & ~prev_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: arms on load, captures two operands, drives the external adder and registers result/overflow
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_btn,
  input  logic         clear_btn,
  input  logic [1:0]   op,
  input  logic [W-1:0] sample,
  input  logic         sample_valid,
  output logic [W:0]   adder_a,
  output logic [W:0]   adder_b,
  output logic         adder_ci,
  input  logic [W:0]   adder_sum,
  output logic [W-1:0] operand1,
  output logic [W-1:0] operand2,
  output logic [W:0]   result,
  output logic         result_valid,
  output logic         overflow,
  output logic         busy,
  output logic [1:0]   led
);
  state_e state_q, state_d;
  logic [W-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [W:0] res_q, res_d;
  logic ovf_q, ovf_d, rv_q, rv_d, sub_q, sub_d;
  logic load_rise, clr_rise;
  edge_detect_rst #(.RST_VAL(1'b1)) u_load (.clk(clk), .rst_n(reset_n), .d_i(load_btn), .rise_o(load_rise));
  edge_detect_rst #(.RST_VAL(1'b1)) u_clear (.clk(clk), .rst_n(reset_n), .d_i(clear_btn), .rise_o(clr_rise));
  always_comb begin
    state_d = state_q;
    op1_d = op1_q;
    op2_d = op2_q;
    res_d = res_q;
    ovf_d = ovf_q;
    rv_d = rv_q;
    sub_d = sub_q;
    if (clr_rise) begin
      state_d = WAIT_A;
      op1_d = '0;
      op2_d = '0;
      res_d = '0;
      ovf_d = 1'b0;
      rv_d = 1'b0;
      sub_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_A: state_d = load_rise ? ARM_A : WAIT_A;
        ARM_A: if (sample_valid) begin
          op1_d = sample;
          state_d = WAIT_B;
        end
        WAIT_B: state_d = load_rise ? ARM_B : WAIT_B;
        ARM_B: if (sample_valid) begin
          op2_d = sample;
          sub_d = op[OP_SUB];
          state_d = COMPUTE;
        end
        COMPUTE: begin
          res_d = adder_sum;
          ovf_d = adder_sum[W] ^ adder_sum[W-1];
          rv_d = 1'b1;
          state_d = DONE;
        end
        DONE: if (load_rise) begin
          rv_d = 1'b0;
          op1_d = op[OP_CHAIN] ? saturate(res_q, ovf_q) : op1_q;
          state_d = op[OP_CHAIN] ? ARM_B : ARM_A;
        end
        default: state_d = WAIT_A;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= WAIT_A;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      rv_q <= 1'b0;
      sub_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      rv_q <= rv_d;
      sub_q <= sub_d;
    end
  assign adder_a = {op1_q[W-1], op1_q};
  assign adder_b = {op2_q[W-1], op2_q} ^ {(W+1){sub_q}};
  assign adder_ci = sub_q;
  assign operand1 = op1_q;
  assign operand2 = op2_q;
  assign result = res_q;
  assign result_valid = rv_q;
  assign overflow = ovf_q;
  assign busy = state_q == ARM_A || state_q == ARM_B || state_q == COMPUTE;
  assign led = state_q == DONE ? LED_DONE : (state_q == WAIT_A || state_q == ARM_A) ? LED_A : LED_B;
endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Controller that sequences the shared 17-bit two's-complement adder of the accelerometer calculator. It arms on a load press, captures each operand from the next valid smoothed sample, and drives a single adder for both add and subtract. It registers the result with a 16-bit overflow flag and supports chaining the previous result as the next first operand. It sits between the smoothing filter and the BCD display mux.

## Interface
Parameters:
- `W`, 16, operand width; the adder and result are `W+1` bits wide.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `load_btn`  in  1  load request, active-high level, already synchronous to `clk`
- `clear_btn`  in  1  clear request, active-high level, already synchronous to `clk`
- `op`  in  2  operation select: bit0 = subtract, bit1 = chain
- `sample`  in  W  signed smoothed sample
- `sample_valid`  in  1  single-cycle strobe marking a new `sample`
- `adder_a`  out  W+1  adder operand A
- `adder_b`  out  W+1  adder operand B
- `adder_ci`  out  1  adder carry-in
- `adder_sum`  in  W+1  combinational sum returned by the external adder
- `operand1`  out  W  captured first operand
- `operand2`  out  W  captured second operand
- `result`  out  W+1  registered result
- `result_valid`  out  1  result is current
- `overflow`  out  1  result does not fit in W bits
- `busy`  out  1  high in the ARM and COMPUTE states
- `led`  out  2  phase indicator

## Operation
- **Edge detection:** rising edges are detected on `load_btn` and `clear_btn`. The previous-value registers reset to 1, so a button held through reset produces no edge.
- **States:**
  - `WAIT_A` (led 01)
  - `ARM_A` (led 01)
  - `WAIT_B` (led 10)
  - `ARM_B` (led 10)
  - `COMPUTE` (led 10)
  - `DONE` (led 11)
- **Transitions:**
  - `WAIT_A`, load edge → `ARM_A`.
  - `ARM_A`, `sample_valid` → `operand1` <= `sample`, go to `WAIT_B`.
  - `WAIT_B`, load edge → `ARM_B`.
  - `ARM_B`, `sample_valid` → `operand2` <= `sample`, latch `op[0]` into `sub_q`, go to `COMPUTE`.
  - `COMPUTE` → `result` <= `adder_sum`, `overflow` <= `adder_sum[W] != adder_sum[W-1]`, `result_valid` <= 1, go to `DONE`.
  - `DONE`, load edge with `op[1]`=0 → clear `result_valid`, go to `ARM_A`.
  - `DONE`, load edge with `op[1]`=1 → `operand1` <= saturated result, clear `result_valid`, go to `ARM_B`.
- **Saturation:** the saturated result is `result[W-1:0]` when there is no overflow. Otherwise it is 16'h7FFF if `result[W]`=0, or 16'h8000 if `result[W]`=1.
- **Adder drive** (combinational, from registered state only):
  - `adder_a` = sign-extended `operand1`.
  - `adder_b` = sign-extended `operand2` XOR {W+1{`sub_q`}}.
  - `adder_ci` = `sub_q`.
- **Clear edge, any state:**
  - go to `WAIT_A`;
  - `operand1`, `operand2`, `result`, `overflow`, `result_valid` and `sub_q` all go to 0.
  - Clear has priority over load and over `sample_valid` in the same cycle.
- **Ignored events:**
  - Load edges in `ARM_A`, `ARM_B` and `COMPUTE`.
  - `sample_valid` outside the ARM states, including the cycle of the arming load edge itself.
- **Mid-operation changes:** `op[0]` changes after the `ARM_B` capture do not affect the pending result. `op[1]` is sampled only at the `DONE` load edge.

## Timing
- **Reset values:**
  - state `WAIT_A`, `led` 01;
  - `operand1`, `operand2`, `result` = 0;
  - `result_valid`, `overflow`, `busy` = 0;
  - `sub_q` = 0, so `adder_a` = `adder_b` = 0 and `adder_ci` = 0.
- **Load latency:** a load edge detected at cycle n (button high at n, low at n-1) puts the state in `ARM_*` at n+1.
- **Capture latency:** `sample_valid` in `ARM_A`/`ARM_B` at cycle m updates the operand at m+1.
- **Result latency:** after the `operand2` capture at m, the state is `COMPUTE` at m+1. `result`, `overflow` and `result_valid` update at m+2.
- **Adder path:** the adder path is combinational within the `COMPUTE` cycle and must close timing in a single cycle.
- **`result_valid`:** a level, held until the next accepted load edge or a clear.

## Structure
- **Package `calc_pkg`:**
  - state enum;
  - op bit positions (`OP_SUB`=0, `OP_CHAIN`=1);
  - `SAT_POS` = 16'h7FFF and `SAT_NEG` = 16'h8000;
  - LED codes.
- **Sub-module `edge_detect_rst`:** a one-bit rising-edge detector with asynchronous active-low reset and a reset value parameter, instantiated twice.
- The adder stays external. This block only drives its ports.

## Test plan
- **Basic add:** load, `sample`=100 valid; load, `sample`=23 valid, `op`=00 → `result`=123 two cycles after the second capture, `overflow`=0, `led`=11.
- **Subtract:** operands 5 and 9, `op`=01 → `result`=17'h1FFFC (−4), `adder_ci`=1 during `COMPUTE`.
- **Overflow and chain:**
  - 16'h7000 + 16'h7000 → `result`=17'h0E000, `overflow`=1.
  - Then load with `op`=10 → `operand1`=16'h7FFF and the state is `ARM_B`.
- **Ignored inputs:**
  - `sample_valid` in the same cycle as the arming load edge is not captured; the next strobe is captured.
  - A second load edge in `ARM_A` is ignored.
- **Clear priority:** clear and load edges in the same cycle during `ARM_B` → `WAIT_A`, all registers 0, `result_valid`=0.
- **Reset behaviour:**
  - `reset_n` asserted during `COMPUTE` → all outputs at reset values immediately.
  - `load_btn` held high through reset release produces no transition until it is released and pressed again.
